uart_transmitter: RTL and testbench

- 8N1 UART transmitter: the sending end of the team's oversampling UART receiver, on the same baud-tick scheme.
- Accepts a parallel byte on a single-cycle request and serialises it LSB first on TX: one start bit, DATA_BITS data bits, STOP_BITS stop bits.
- Each bit is held for TICKS_PER_BIT assertions of the shared ENABLE tick.
- Signals frame completion with a one-cycle pulse on priznak_end_transmitter, which feeds the receiver's input of the same name.

---
 rtl/uart_pkg.sv | 7 +
 rtl/uart_transmitter.sv | 89 ++++++++
 tb/tb_uart_transmitter.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART frame parameters and transmitter state type
package uart_pkg;
    localparam int UART_DATA_BITS     = 8;
    localparam int UART_TICKS_PER_BIT = 5;
    localparam int UART_STOP_BITS     = 1;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
endpackage

// File: rtl/uart_transmitter.sv
// uart_transmitter: 8N1 serialiser, LSB first, each bit held TICKS_PER_BIT ENABLE ticks
// ports: clk, res (async active-low), ENABLE tick, START_TX + word_transmitter request, TX line, BUSY, priznak_end_transmitter frame-end pulse
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int DATA_BITS     = UART_DATA_BITS,
    parameter int TICKS_PER_BIT = UART_TICKS_PER_BIT,
    parameter int STOP_BITS     = UART_STOP_BITS
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic                 ENABLE,
    input  logic                 START_TX,
    input  logic [DATA_BITS-1:0] word_transmitter,
    output logic                 TX,
    output logic                 BUSY,
    output logic                 priznak_end_transmitter
);
    localparam int TW = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
    localparam int BW = $clog2(DATA_BITS + 1);
    tx_state_t state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic tx_q, tx_d, busy_q, busy_d, done_q, done_d;
    logic cell_end, last_data, last_stop;
    assign cell_end  = ENABLE && tick_q == TW'(TICKS_PER_BIT - 1);
    assign last_data = bit_q == BW'(DATA_BITS - 1);
    assign last_stop = bit_q == BW'(STOP_BITS - 1);
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (state_q != IDLE && ENABLE) tick_d = cell_end ? '0 : tick_q + 1'b1;
        case (state_q)
            IDLE: if (START_TX) begin
                shift_d = word_transmitter;
                busy_d  = 1'b1;
                tx_d    = 1'b0;
                tick_d  = '0;
                bit_d   = '0;
                state_d = START;
            end
            START: if (cell_end) begin
                tx_d    = shift_q[0];
                state_d = DATA;
            end
            DATA: if (cell_end) begin
                shift_d = shift_q >> 1;
                tx_d    = last_data | shift_d[0];
                bit_d   = last_data ? '0 : bit_q + 1'b1;
                state_d = last_data ? STOP : DATA;
            end
            STOP: if (cell_end) begin
                bit_d   = last_stop ? '0 : bit_q + 1'b1;
                busy_d  = !last_stop;
                done_d  = last_stop;
                state_d = last_stop ? IDLE : STOP;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end
    assign TX                      = tx_q;
    assign BUSY                    = busy_q;
    assign priznak_end_transmitter = done_q;
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: frame-level model plus directed vectors for uart_transmitter
module tb_uart_transmitter;
    localparam int TPB = 5;
    localparam int DB = 8;
    localparam int TOTAL = (1 + DB + 1) * TPB;
    logic clk = 0;
    logic res;
    logic ENABLE;
    logic START_TX = 0;
    logic [7:0] word = 0;
    logic TX, BUSY, done;
    int en_period = 1;
    int cyc_cnt = 0;
    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int busy_len = 0;
    int last_len = 0;
    logic m_act, m_done;
    int m_n;
    logic [7:0] m_byte;
    logic exp_tx;
    uart_transmitter dut (
        .clk(clk), .res(res), .ENABLE(ENABLE), .START_TX(START_TX),
        .word_transmitter(word), .TX(TX), .BUSY(BUSY), .priznak_end_transmitter(done)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
    assign ENABLE = (en_period == 1) || (cyc_cnt % en_period == 0);
    function automatic logic tx_at(int n, logic [7:0] b);
        int c;
        c = n / TPB;
        return c == 0 ? 1'b0 : (c <= DB ? b[c-1] : 1'b1);
    endfunction
    always @(posedge clk or negedge res) begin
        if (!res) begin
            m_act  <= 1'b0;
            m_done <= 1'b0;
            m_n    <= 0;
            m_byte <= 8'h00;
        end else begin
            m_done <= 1'b0;
            if (!m_act) begin
                if (START_TX) begin
                    m_act  <= 1'b1;
                    m_byte <= word;
                    m_n    <= 0;
                end
            end else if (ENABLE) begin
                if (m_n == TOTAL - 1) begin
                    m_act  <= 1'b0;
                    m_done <= 1'b1;
                end else m_n <= m_n + 1;
            end
        end
    end
    assign exp_tx = m_act ? tx_at(m_n, m_byte) : 1'b1;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    always @(posedge clk) begin
        #1;
        chk("model_tx", TX, exp_tx);
        chk("model_busy", BUSY, m_act);
        chk("model_done", done, m_done);
        if (done) done_cnt++;
        if (BUSY) busy_len++;
        else if (busy_len > 0) begin
            last_len = busy_len;
            busy_len = 0;
        end
    end
    task automatic sample_frame(input logic [7:0] w, input int inj, input logic [7:0] iw, output logic [9:0] bits);
        @(negedge clk);
        START_TX = 1;
        word = w;
        @(posedge clk);
        #1;
        START_TX = 0;
        for (int c = 0; c < TOTAL; c++) begin
            if (c % TPB == 0) bits[c/TPB] = TX;
            if (c == inj) begin
                START_TX = 1;
                word = iw;
            end else if (c == inj + 1) START_TX = 0;
            @(posedge clk);
            #1;
        end
    endtask
    initial begin
        logic [9:0] bits;
        int d0, n;
        res = 0;
        repeat (10) begin
            @(negedge clk);
            START_TX = 1'($urandom_range(0, 1));
            word = 8'($urandom);
        end
        #1;
        chk("reset_tx", TX, 1);
        chk("reset_busy", BUSY, 0);
        chk("reset_done", done, 0);
        @(negedge clk);
        START_TX = 0;
        res = 1;
        repeat (100) @(posedge clk);
        #1;
        chk("idle_tx", TX, 1);
        chk("idle_done_cnt", done_cnt, 0);
        sample_frame(8'hA5, -1, 8'h00, bits);
        chk("a5_bits", bits, 10'b1101001010);
        chk("a5_done_edge51", done, 1);
        chk("a5_busy_fallen", BUSY, 0);
        @(posedge clk);
        #2;
        chk("a5_busy_len", last_len, 50);
        en_period = 4;
        @(negedge clk);
        while (cyc_cnt % 4 != 0) @(negedge clk);
        START_TX = 1;
        word = 8'h3C;
        @(posedge clk);
        #1;
        START_TX = 0;
        n = 0;
        while (!done && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("3c_frame_clks", n, 200);
        @(posedge clk);
        #2;
        chk("3c_busy_len", last_len, 200);
        en_period = 1;
        d0 = done_cnt;
        sample_frame(8'h55, 10, 8'hFF, bits);
        chk("rej_done", done, 1);
        chk("rej_data", bits[8:1], 8'h55);
        chk("rej_start_stop", {bits[9], bits[0]}, 2'b10);
        repeat (3) @(posedge clk);
        #2;
        chk("rej_one_pulse", done_cnt - d0, 1);
        chk("rej_busy_len", last_len, 50);
        @(negedge clk);
        START_TX = 1;
        word = 8'h00;
        @(posedge clk);
        #1;
        word = 8'hFF;
        for (int c = 0; c < TOTAL; c++) begin
            if (c % TPB == 0) bits[c/TPB] = TX;
            @(posedge clk);
            #1;
        end
        chk("b2b_first", bits, 10'b1000000000);
        chk("b2b_first_done", done, 1);
        @(posedge clk);
        #1;
        chk("b2b_second_busy", BUSY, 1);
        for (int c = 0; c < TOTAL; c++) begin
            if (c % TPB == 0) bits[c/TPB] = TX;
            @(posedge clk);
            #1;
        end
        chk("b2b_second", bits, 10'b1111111110);
        chk("b2b_second_done", done, 1);
        @(posedge clk);
        repeat (23) @(posedge clk);
        #1;
        chk("mid_busy", BUSY, 1);
        d0 = done_cnt;
        res = 0;
        START_TX = 0;
        #1;
        chk("mid_reset_tx", TX, 1);
        chk("mid_reset_busy", BUSY, 0);
        chk("mid_reset_done", done, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        res = 1;
        repeat (60) @(posedge clk);
        #2;
        chk("post_reset_pulses", done_cnt - d0, 0);
        chk("post_reset_tx", TX, 1);
        chk("post_reset_busy", BUSY, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end
endmodule
